keypad_scan_onehot: RTL
=======================

# keypad_scan_onehot

4x4 matrix keypad scanner and debouncer. Sits directly upstream of the keypad-to-digit encoder: it drives the keypad rows, samples the columns, debounces whole-matrix snapshots, and presents the held key as a 16-bit one-hot level that the encoder decodes. It also emits a one-cycle press strobe and a 4-bit key index for other consumers.

## Interface
- SCAN_DIV, 50000: clk cycles each row is driven before its columns are sampled (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_FRAMES, 4: number of consecutive identical full-matrix frames required before the snapshot is accepted; minimum 1.
- clk  input  1  system clock, 50 MHz.
- RSTn  input  1  reset; asynchronous, active-high.
- col_in  input  4  keypad columns, active-low (pulled up), asynchronous to clk.
- row_out  output  4  keypad row drive, active-low, exactly one bit low at all times.
- onehot  output  16  debounced key level; bit index = row*4 + col; 16'h0000 when no key is accepted.
- key_valid  output  1  one-cycle strobe on each new non-zero onehot value.
- key_code  output  4  index of the set onehot bit; holds its last value when onehot is zero.

## Operation
- col_in passes through a 2-flop synchronizer, then is inverted (1 = pressed).
- Scan: row index r cycles 0,1,2,3,0,...; row_out = ~(4'b0001 << r). A divider counts 0..SCAN_DIV-1 per row; at count SCAN_DIV-1 the synchronized columns are written into frame[r*4 +: 4], the divider clears and r advances.
- A frame completes when row 3 is sampled. At frame completion: if frame == cand, stable_cnt increments, saturating at DEBOUNCE_FRAMES; otherwise cand <= frame and stable_cnt <= 1.
- stable_map <= cand on the cycle stable_cnt equals DEBOUNCE_FRAMES (evaluated after update). Stable_map otherwise holds.
- Decode (registered): exactly one bit set in stable_map -> onehot = stable_map, key_code = its index. Zero bits -> onehot = 0. Multiple bits: see Configuration.
- key_valid pulses for one cycle when the registered onehot changes to a non-zero value different from its previous value. Release (-> 0) and re-press of the same key produce a new strobe; a direct change key A -> key B also strobes.
- onehot is a level held as long as the key stays stably pressed; there is no auto-repeat.

## Timing
- Reset values: row_out = 4'b1110, onehot = 16'h0000, key_valid = 0, key_code = 4'h0; divider, r, frame, cand, stable_cnt and stable_map all cleared.
- Frame period = 4*SCAN_DIV cycles. Column samples taken 2 sync cycles + (SCAN_DIV-3) settle cycles after the row is driven.
- Latency: a press stable before frame k starts produces onehot at the end of frame k+DEBOUNCE_FRAMES-1, plus 2 cycles (stable_map register, decode register); key_valid in that same cycle as onehot changes. Release latency is identical.
- Bounce shorter than one frame and inconsistent across frames never reaches onehot.
- Reset asserted mid-scan: all state cleared immediately; scan restarts at row 0 with a full debounce window; no strobe is produced by reset.

## Configuration
- KEYPAD_MULTI_REJECT_EN defined: any stable_map with two or more bits set decodes to onehot = 16'h0000 (multi-key and ghost patterns are ignored, no strobe).
- Not defined: the lowest-index set bit wins; onehot carries that single bit and key_code its index.

## Test plan
Benches use SCAN_DIV=4, DEBOUNCE_FRAMES=2 (frame = 16 cycles).
- Reset, no keys -> row_out walks 1110,1101,1011,0111 every 4 cycles; onehot stays 16'h0000, key_valid never pulses.
- Key row 2 col 1 held (col_in[1] low whenever row_out[2] low) -> onehot = 16'h0200, key_code = 9, single key_valid pulse, within 2 frames + 2 cycles of a full stable frame; release -> onehot returns to 0 with no pulse.
- Same key bouncing with a 1-frame press then 1-frame release, repeated -> onehot remains 16'h0000.
- Key 0 held, then key 15 pressed as well, then key 0 released -> with KEYPAD_MULTI_REJECT_EN: 0x0001, 0x0000, 0x8000 with two key_valid pulses; without: 0x0001 held through overlap, then 0x8000, two pulses.
- Key 5 stably held, RSTn pulsed mid-frame -> outputs return to reset values at once; onehot = 16'h0020 reappears after the debounce window with a fresh key_valid.
- Key 3 press, release, press again -> two key_valid pulses, key_code = 3 retained during release.

Source files
------------

// File: rtl/keypad_scan_onehot_if.sv
// Keypad scanner port bundle: column sense in, row drive and debounced key outputs.
interface keypad_scan_onehot_if;
  localparam int unsigned LINES = 4;
  localparam int unsigned KEYS  = 16;

  logic [LINES-1:0] col_in;
  logic [LINES-1:0] row_out;
  logic [KEYS-1:0]  onehot;
  logic             key_valid;
  logic [3:0]       key_code;

  modport master (
    input  col_in,
    output row_out,
    output onehot,
    output key_valid,
    output key_code
  );

  modport slave (
    output col_in,
    input  row_out,
    input  onehot,
    input  key_valid,
    input  key_code
  );
endinterface

// File: rtl/keypad_scan_onehot.sv
// 4x4 keypad row scanner with whole-frame debounce and one-hot key level output.
// Define KEYPAD_MULTI_REJECT_EN to suppress multi-key / ghost patterns instead of lowest-index-wins.
module keypad_scan_onehot #(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input logic                 clk,
  input logic                 RSTn,
  keypad_scan_onehot_if.master bus
);
  localparam int unsigned COLS  = 4;
  localparam int unsigned KEYS  = 16;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [COLS-1:0]  col_s1;
  logic [COLS-1:0]  col_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       row;
  logic [KEYS-1:0]  frame;
  logic [KEYS-1:0]  cand;
  logic [CNT_W-1:0] stable_cnt;
  logic [KEYS-1:0]  stable_map;

  logic             row_tick_c;
  logic             frame_done_c;
  logic [1:0]       row_nxt_c;
  logic [KEYS-1:0]  frame_next_c;
  logic [KEYS-1:0]  dec_onehot_c;
  logic [3:0]       dec_code_c;
  logic [3:0]       low_idx_c;

  assign row_tick_c   = (div == DIV_LAST);
  assign frame_done_c = row_tick_c && (row == 2'd3);
  assign row_nxt_c    = row + 2'd1;

  // Current frame with this row's pressed columns merged in.
  always_comb begin
    frame_next_c = frame;
    frame_next_c[{row, 2'b00} +: COLS] = ~col_s2;
  end

  // Lowest-index key wins unless multi-key rejection is enabled.
  always_comb begin
    dec_onehot_c = '0;
    dec_code_c   = bus.key_code;
    low_idx_c    = '0;
    for (int i = int'(KEYS) - 1; i >= 0; i--) begin
      if (stable_map[i]) low_idx_c = 4'(i);
    end
`ifdef KEYPAD_MULTI_REJECT_EN
    if ((stable_map != '0) && ((stable_map & (stable_map - 16'd1)) == '0)) begin
      dec_onehot_c = stable_map;
      dec_code_c   = low_idx_c;
    end
`else
    if (stable_map != '0) begin
      dec_onehot_c = 16'd1 << low_idx_c;
      dec_code_c   = low_idx_c;
    end
`endif
  end

  always_ff @(posedge clk or posedge RSTn) begin
    if (RSTn) begin
      col_s1        <= '1;
      col_s2        <= '1;
      div           <= '0;
      row           <= '0;
      frame         <= '0;
      cand          <= '0;
      stable_cnt    <= '0;
      stable_map    <= '0;
      bus.row_out   <= 4'b1110;
      bus.onehot    <= '0;
      bus.key_valid <= 1'b0;
      bus.key_code  <= '0;
    end else begin
      col_s1 <= bus.col_in;
      col_s2 <= col_s1;

      if (row_tick_c) begin
        div         <= '0;
        row         <= row_nxt_c;
        bus.row_out <= ~(4'b0001 << row_nxt_c);
        frame       <= frame_next_c;
      end else begin
        div <= div + DIV_W'(1);
      end

      // Debounce on whole frames: identical consecutive frames build confidence.
      if (frame_done_c) begin
        if (frame_next_c == cand) begin
          if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_W'(1);
        end else begin
          cand       <= frame_next_c;
          stable_cnt <= CNT_W'(1);
        end
      end

      if (stable_cnt == CNT_MAX) stable_map <= cand;

      bus.onehot    <= dec_onehot_c;
      bus.key_code  <= dec_code_c;
      bus.key_valid <= (dec_onehot_c != '0) && (dec_onehot_c != bus.onehot);
    end
  end
endmodule
